// File: rtl/ramp_control.sv
// rtl/ramp_control.sv - target-tracking ramp counter with approach/triangle/sawtooth/hold modes
//
// Purpose: moves value toward a loaded target by step_r per tick. A tick fires
// every div_r+1 enabled cycles. All arithmetic is done one bit wider than WIDTH
// and then clamped, so value never wraps.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load            capture target/step/mode/div, clear value, prescaler and dir
//   retarget        capture target only; dir follows the new target
//   target, step    endpoint and increment (step 0 is treated as 1)
//   mode            00 approach, 01 triangle, 10 sawtooth, 11 hold
//   div             tick divider
//   en              tick enable; low freezes prescaler and value
//   value           current count
//   busy            block still moving
//   done            one-cycle pulse when a tick lands value on target
//   dir             0 up, 1 down
module ramp_control #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             retarget,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] step,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic             en,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             dir
);

  localparam logic [1:0] MODE_APPROACH = 2'b00;
  localparam logic [1:0] MODE_TRIANGLE = 2'b01;
  localparam logic [1:0] MODE_SAWTOOTH = 2'b10;

  logic [WIDTH-1:0] target_r;
  logic [WIDTH-1:0] step_r;
  logic [1:0]       mode_r;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] pc;

  logic             tick;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] up_to_target;
  logic [WIDTH-1:0] down_to_target;
  logic [WIDTH-1:0] down_to_zero;
  logic [WIDTH-1:0] tick_value;
  logic             tick_dir;
  logic             hits_target;

  always_comb begin
    tick = en && (pc == div_r);

    // Widened add/sub: sum[WIDTH] is the carry, diff[WIDTH] the borrow.
    sum  = {1'b0, value} + {1'b0, step_r};
    diff = {1'b0, value} - {1'b0, step_r};

    up_to_target   = (sum > {1'b0, target_r}) ? target_r : sum[WIDTH-1:0];
    down_to_target = (diff[WIDTH] || (diff[WIDTH-1:0] < target_r)) ? target_r : diff[WIDTH-1:0];
    down_to_zero   = diff[WIDTH] ? '0 : diff[WIDTH-1:0];

    tick_value = value;
    tick_dir   = dir;
    case (mode_r)
      MODE_APPROACH: begin
        if (value < target_r) begin
          tick_value = up_to_target;
          tick_dir   = 1'b0;
        end else if (value > target_r) begin
          tick_value = down_to_target;
          tick_dir   = 1'b1;
        end
      end
      MODE_TRIANGLE: begin
        // A zero target collapses the sweep; leave everything where it is.
        if (target_r != '0) begin
          if (!dir) begin
            tick_value = up_to_target;
            if (up_to_target == target_r) tick_dir = 1'b1;
          end else begin
            tick_value = down_to_zero;
            if (down_to_zero == '0) tick_dir = 1'b0;
          end
        end
      end
      MODE_SAWTOOTH: begin
        tick_dir = 1'b0;
        if (value >= target_r) tick_value = '0;
        else                   tick_value = up_to_target;
      end
      default: begin
      end
    endcase

    // done only for a tick that actually moves value onto a nonzero target.
    hits_target = (tick_value != value) && (tick_value == target_r) && (target_r != '0);
  end

  always_comb begin
    busy = 1'b0;
    case (mode_r)
      MODE_APPROACH: busy = (value != target_r);
      MODE_TRIANGLE: busy = (target_r != '0);
      MODE_SAWTOOTH: busy = (target_r != '0);
      default:       busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value    <= '0;
      target_r <= '0;
      step_r   <= WIDTH'(1);
      mode_r   <= MODE_APPROACH;
      div_r    <= '0;
      pc       <= '0;
      dir      <= 1'b0;
      done     <= 1'b0;
    end else if (load) begin
      target_r <= target;
      step_r   <= (step == '0) ? WIDTH'(1) : step;
      mode_r   <= mode;
      div_r    <= div;
      value    <= '0;
      pc       <= '0;
      dir      <= 1'b0;
      done     <= 1'b0;
    end else if (retarget) begin
      target_r <= target;
      dir      <= (value > target);
      done     <= 1'b0;
    end else begin
      done <= tick && hits_target;
      if (tick) begin
        pc    <= '0;
        value <= tick_value;
        dir   <= tick_dir;
      end else if (en) begin
        pc <= pc + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ramp_control.sv
// tb/tb_ramp_control.sv - randomized and directed bench for ramp_control
module tb_ramp_control;

  localparam int WIDTH = 8;
  localparam int DIV_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic             retarget;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] step;
  logic [1:0]       mode;
  logic [DIV_W-1:0] div;
  logic             en;
  logic [WIDTH-1:0] value;
  logic             busy;
  logic             done;
  logic             dir;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  ramp_control #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .load(load), .retarget(retarget),
    .target(target), .step(step), .mode(mode), .div(div), .en(en),
    .value(value), .busy(busy), .done(done), .dir(dir)
  );

  always #5 clk = ~clk;

  // Reference model in plain integers: clamping is just min/max on ints.
  int m_value, m_target, m_step, m_mode, m_div, m_pc;
  bit m_dir, m_done;

  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

  always @(posedge clk) begin
    int old;
    bit t;
    if (rst) begin
      m_value = 0; m_target = 0; m_step = 1; m_mode = 0; m_div = 0; m_pc = 0;
      m_dir = 0; m_done = 0;
    end else if (load) begin
      m_target = target; m_step = (step == 0) ? 1 : int'(step);
      m_mode = mode; m_div = div; m_value = 0; m_pc = 0; m_dir = 0; m_done = 0;
    end else if (retarget) begin
      m_dir = (m_value > int'(target));
      m_target = target;
      m_done = 0;
    end else begin
      m_done = 0;
      t = en && (m_pc == m_div);
      if (en) m_pc = t ? 0 : m_pc + 1;
      if (t) begin
        old = m_value;
        case (m_mode)
          0: if (m_value < m_target) begin
               m_value = imin(m_value + m_step, m_target); m_dir = 0;
             end else if (m_value > m_target) begin
               m_value = imax(m_value - m_step, m_target); m_dir = 1;
             end
          1: if (m_target != 0) begin
               if (!m_dir) begin
                 m_value = imin(m_value + m_step, m_target);
                 if (m_value == m_target) m_dir = 1;
               end else begin
                 m_value = imax(m_value - m_step, 0);
                 if (m_value == 0) m_dir = 0;
               end
             end
          2: begin
               m_dir = 0;
               m_value = (m_value >= m_target) ? 0 : imin(m_value + m_step, m_target);
             end
          default: ;
        endcase
        m_done = (m_value != old) && (m_value == m_target) && (m_target != 0);
      end
    end
  end

  always @(negedge clk) begin
    bit exp_busy;
    if (chk_en) begin
      case (m_mode)
        0: exp_busy = (m_value != m_target);
        1, 2: exp_busy = (m_target != 0);
        default: exp_busy = 0;
      endcase
      checks++;
      if (int'(value) != m_value || busy != exp_busy || done != m_done || dir != m_dir) begin
        errors++;
        $display("FAIL model t=%0t: value=%0d busy=%0b done=%0b dir=%0b expected value=%0d busy=%0b done=%0b dir=%0b",
                 $time, value, busy, done, dir, m_value, exp_busy, m_done, m_dir);
      end
    end
  end

  task automatic lit(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int t, input int s, input int m, input int d);
    target = WIDTH'(t); step = WIDTH'(s); mode = 2'(m); div = DIV_W'(d);
    load = 1; cyc(); load = 0;
  endtask

  initial begin
    int v1[5] = '{0, 2, 4, 5, 5};
    int d1[5] = '{0, 0, 0, 1, 0};
    int b1[5] = '{1, 1, 1, 0, 0};
    int v3[7] = '{0, 3, 4, 1, 0, 3, 4};
    int d3[7] = '{0, 0, 1, 0, 0, 0, 1};
    int r3[7] = '{0, 0, 1, 1, 0, 0, 1};
    int v4[10] = '{0, 0, 0, 2, 2, 2, 4, 4, 4, 5};
    int v6[4] = '{0, 200, 255, 255};
    int d6[4] = '{0, 0, 1, 0};

    rst = 1; load = 0; retarget = 0; target = 0; step = 0; mode = 0; div = 0; en = 1;
    cyc();
    chk_en = 1;
    cyc();
    lit("reset_value", value, 0);
    lit("reset_busy", busy, 0);
    lit("reset_done", done, 0);
    lit("reset_dir", dir, 0);
    rst = 0;

    do_load(5, 2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      lit("approach_value", value, v1[i]);
      lit("approach_done", done, d1[i]);
      lit("approach_busy", busy, b1[i]);
      cyc();
    end

    target = 1; retarget = 1; cyc(); retarget = 0;
    lit("retarget_value", value, 5);
    lit("retarget_dir", dir, 1);
    cyc(); lit("retarget_v3", value, 3);
    cyc(); lit("retarget_v1", value, 1); lit("retarget_done", done, 1);
    cyc(); lit("retarget_done_drop", done, 0); lit("retarget_busy", busy, 0);

    do_load(4, 3, 1, 0);
    for (int i = 0; i < 7; i++) begin
      lit("triangle_value", value, v3[i]);
      lit("triangle_done", done, d3[i]);
      lit("triangle_dir", dir, r3[i]);
      cyc();
    end

    do_load(5, 2, 2, 2);
    for (int i = 0; i < 10; i++) begin
      lit("saw_value", value, v4[i]);
      if (i < 9) cyc();
    end
    lit("saw_done", done, 1);
    en = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      lit("freeze_value", value, 5);
    end
    en = 1;
    for (int i = 0; i < 12; i++) cyc();

    do_load(3, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      lit("step0_value", value, i);
      cyc();
    end
    target = 9; step = 1; mode = 0; div = 0;
    load = 1; retarget = 1; cyc(); load = 0; retarget = 0;
    lit("load_wins_value", value, 0);
    cyc(); cyc();
    rst = 1; cyc(); rst = 0;
    lit("midrst_value", value, 0);
    lit("midrst_done", done, 0);
    lit("midrst_busy", busy, 0);

    do_load(255, 200, 0, 0);
    for (int i = 0; i < 4; i++) begin
      lit("clamp_value", value, v6[i]);
      lit("clamp_done", done, d6[i]);
      cyc();
    end

    do_load(7, 1, 3, 0);
    for (int i = 0; i < 5; i++) begin
      lit("hold_value", value, 0);
      lit("hold_busy", busy, 0);
      cyc();
    end

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      rst = (r == 0);
      load = (r >= 1 && r <= 3);
      retarget = (r >= 4 && r <= 6) || (r == 7);
      target = WIDTH'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) target = 0;
      step = WIDTH'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 6));
      mode = 2'($urandom_range(0, 3));
      div = DIV_W'($urandom_range(0, 4) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 2));
      en = ($urandom_range(0, 9) < 8);
      cyc();
    end
    rst = 0; load = 0; retarget = 0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ramp_control.md
# ramp_control

Parametrised target-tracking counter: the next generation of the team's single-channel "count to loaded target" control block. A target, step size and tick divider are loaded through a simple strobe interface. The output value then moves toward the target in one of four modes: one-shot approach (up or down), triangle sweep, sawtooth wrap, or hold. Sits between switch/UART-derived control inputs and the LED/actuator outputs, and exposes busy/done status for the upstream sequencer.

## Interface
- WIDTH, 8, width of value, target and step
- DIV_W, 4, width of tick divider
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- load  in  1  strobe: capture target/step/mode/div, clear value to 0
- retarget  in  1  strobe: capture target only, value kept
- target  in  WIDTH  endpoint
- step  in  WIDTH  increment per tick; 0 treated as 1
- mode  in  2  00 approach, 01 triangle, 10 sawtooth, 11 hold
- div  in  DIV_W  tick every div+1 enabled cycles
- en  in  1  tick enable; low freezes prescaler and value
- value  out  WIDTH  current count
- busy  out  1  block still moving
- done  out  1  one-cycle pulse when value reaches target
- dir  out  1  0 up, 1 down

## Operation
- Priority per cycle: rst > load > retarget > tick.
- rst: value=0, target_r=0, step_r=1, mode_r=00, div_r=0, prescaler pc=0, dir=0, done=0.
- load: capture target_r, step_r (0→1), mode_r, div_r; value=0, pc=0, dir=0, done=0. No tick in a load cycle.
- retarget: target_r=target; mode_r/step_r/div_r/value/pc unchanged; dir=1 if value>target else 0; done=0 that cycle; no tick that cycle.
- Prescaler: tick = en & (pc==div_r). On tick pc=0; else if en, pc=pc+1; else pc holds.
- All add/sub done in WIDTH+1 bits, then clamped. No silent overflow or underflow.
- Mode 00, approach: on tick, if value<target_r then value=min(value+step_r,target_r), dir=0. If value>target_r then value=max(value−step_r,target_r), dir=1. Equal: no change.
- Mode 01, triangle, dir=0: value=min(value+step_r,target_r); on reaching target_r set dir=1.
- Mode 01, triangle, dir=1: value=max(value−step_r,0); on reaching 0 set dir=0.
- Mode 01 with target_r=0: value stays 0, no done.
- Mode 10, sawtooth: on tick, if value>=target_r then value=0, else value=min(value+step_r,target_r). dir=0 always. With target_r=0, value stays 0 and no done.
- Mode 11, hold: ticks ignored; value and dir frozen; pc still runs.
- done: registered; high exactly in the cycle after the edge at which a tick changes value to equal target_r. Never asserted by load, retarget or hold. With target_r=0, done never fires.
- busy (combinational from registers):
  - mode 00: value≠target_r
  - modes 01/10: target_r≠0
  - mode 11: 0
  - busy ignores en.
- Mode changes only via load.

## Timing
- Reset value of every output: value=0, busy=0, done=0, dir=0.
- load/retarget effects visible the cycle after the strobe edge.
- First tick after load: div_r+1 enabled cycles after the load edge. With div=0 and en=1, value first changes one cycle after the load is visible.
- done and the value that equals target appear on the same cycle; done drops the next cycle.
- Reset mid-sweep aborts immediately; no done pulse is emitted.

## Test plan
- rst, then load target=5 step=2 mode=00 div=0 en=1 → value 0,2,4,5,5…; done high only with the first 5; busy falls with 5.
- From value=5 (mode 00), retarget target=1 → dir=1, value 3,1; done with 1; busy=0 after.
- load target=4 step=3 mode=01 div=0 → value 0,3,4,1,0,3,4…; done pulses at each 4; dir toggles at 4 and at 0.
- load target=5 step=2 mode=10 div=2 → value changes every 3 cycles: 0,2,4,5,0,2…; done at each 5. Drop en for 4 cycles mid-run → value and pc frozen, then resume with the same phase.
- load step=0 target=3 mode=00 → steps of 1 (0,1,2,3). Assert load and retarget together → load wins, value=0. rst asserted mid-ramp → all outputs 0 next cycle, no done.
- WIDTH=8, load target=255 step=200 mode=00 → 0,200,255 (clamped, no wrap); done at 255. Mode 11 with en=1 → value constant.
